apb_regbank_completer: RTL and testbench

//  APB completer (responder) for the APB master/slave subsystem: word-addressed register bank with programmable wait states.

---
 rtl/apb_pkg.sv | 9 +
 rtl/apb_wait_ctr.sv | 18 +
 rtl/apb_regbank_completer.sv | 104 ++++++++++
 tb/tb_apb_regbank_completer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared APB completer constants and FSM state encoding.
package apb_pkg;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int REG0_IDX   = 0;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
endpackage

// File: rtl/apb_wait_ctr.sv
// apb_wait_ctr: loadable down-counter with zero flag for APB wait-state insertion.
module apb_wait_ctr #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : dec_i ? cnt_q - W'(1) : cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/apb_regbank_completer.sv
// apb_regbank_completer: APB completer with word register bank, wait states and error responses.
// Optional byte strobes via `define APB_PSTRB_EN.
module apb_regbank_completer
    import apb_pkg::*;
#(
    parameter int          ADDR_W      = APB_ADDR_W,
    parameter int          DATA_W      = APB_DATA_W,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                pclk_i,
    input  logic                presetn_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [ADDR_W-1:0]   paddr_i,
    input  logic [DATA_W-1:0]   pwdata_i,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0] pstrb_i,
`endif
    output logic [DATA_W-1:0]   prdata_o,
    output logic                pready_o,
    output logic                pslverr_o
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_W / 8;
    localparam int CW     = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, a_addr;
    logic [DATA_W-1:0] wdata_q, wmask, rdval, prdata_q, prdata_d;
    logic [STRB_W-1:0] strb_q, strb_in;
    logic              write_q, a_write, pready_q, pslverr_q, pslverr_d;
    logic              setup, err, commit, cnt_zero;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

`ifdef APB_PSTRB_EN
    assign strb_in = pstrb_i;
`else
    assign strb_in = '1;
`endif

    // In IDLE the live bus is the access being set up; later the captured copy is authoritative.
    assign a_addr  = state_q == IDLE ? paddr_i : addr_q;
    assign a_write = state_q == IDLE ? pwrite_i : write_q;
    assign idx     = a_addr[2+:IDX_W];
    assign setup   = psel_i & ~penable_i;
    assign err     = (a_addr[1:0] != 2'b00) || (int'(idx) >= NUM_REGS) || (|(a_addr >> (2 + IDX_W)))
                     || (a_write && idx == IDX_W'(REG0_IDX));
    assign rdval   = idx == IDX_W'(REG0_IDX) ? DATA_W'(ID_VALUE) : regs_q[idx];
    assign commit  = state_q == RESP && psel_i && penable_i && pwrite_i && write_q && !err;

    always_comb begin
        state_d   = state_q == IDLE ? (setup ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE)
                  : state_q == WAIT ? (!psel_i ? IDLE : cnt_zero ? RESP : WAIT)
                  : IDLE;
        pslverr_d = state_d == RESP && err;
        prdata_d  = (state_d == RESP && !err && !a_write) ? rdval : '0;
        for (int i = 0; i < STRB_W; i++) wmask[i*8+:8] = {8{strb_q[i]}};
    end

    apb_wait_ctr #(.W(CW)) u_wait_ctr (
        .clk_i      (pclk_i),
        .rst_ni     (presetn_i),
        .load_i     (state_q == IDLE && setup),
        .load_val_i (LOAD_VAL),
        .dec_i      (state_q == WAIT && psel_i && !cnt_zero),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge pclk_i or negedge presetn_i)
        if (!presetn_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            write_q   <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prdata_q  <= prdata_d;
            pready_q  <= state_d == RESP;
            pslverr_q <= pslverr_d;
            if (state_q == IDLE && setup) begin
                addr_q  <= paddr_i;
                wdata_q <= pwdata_i;
                strb_q  <= strb_in;
                write_q <= pwrite_i;
            end
        end

    always_ff @(posedge pclk_i or negedge presetn_i)
        if (!presetn_i) for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        else if (commit) regs_q[idx] <= (regs_q[idx] & ~wmask) | (wdata_q & wmask);

    assign prdata_o  = prdata_q;
    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
endmodule

// File: tb/tb_apb_regbank_completer.sv
// tb_apb_regbank_completer: directed checks of the APB register-bank completer.
// A second instance built with zero wait states shares the bus.
module tb_apb_regbank_completer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata, prdata0;
    logic        pready, pslverr, pready0, pslverr0;
`ifdef APB_PSTRB_EN
    logic [3:0]  pstrb = 4'hF;
`endif
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    apb_regbank_completer dut (
        .pclk_i(clk), .presetn_i(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb_i(pstrb),
`endif
        .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr)
    );

    apb_regbank_completer #(.WAIT_CYCLES(0)) dut0 (
        .pclk_i(clk), .presetn_i(rst_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata),
`ifdef APB_PSTRB_EN
        .pstrb_i(pstrb),
`endif
        .prdata_o(prdata0), .pready_o(pready0), .pslverr_o(pslverr0)
    );

    // Called right after a rising edge; returns on the next one, so calls chain back-to-back.
    task automatic xfer(input bit d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int n);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd;
        @(posedge clk); #1 penable = 1'b1;
        n = 0;
        forever begin
            @(negedge clk); n++;
            if ((d ? pready0 : pready) === 1'b1 || n > 20) break;
        end
        rd = d ? prdata0 : prdata;
        err = d ? pslverr0 : pslverr;
        n_checks++;
        if (n > 20) begin $display("FAIL timeout addr=%h: PREADY never rose", a); n_fail++; end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (pready !== 1'b0) begin $display("FAIL reset_pready got %b want 0", pready); n_fail++; end
        n_checks++; if (prdata !== 32'h0) begin $display("FAIL reset_prdata got %h want 0", prdata); n_fail++; end
        n_checks++; if (pslverr !== 1'b0) begin $display("FAIL reset_pslverr got %b want 0", pslverr); n_fail++; end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_write();
        logic [31:0] rd; logic e; int n;
        xfer(0, 1, 32'h04, 32'h1234_5678, rd, e, n);
        n_checks++; if (e !== 1'b0) begin $display("FAIL wr04_err got %b want 0", e); n_fail++; end
        n_checks++; if (n != 3) begin $display("FAIL wr04_latency got %0d want 3", n); n_fail++; end
        xfer(0, 0, 32'h04, 32'h0, rd, e, n);
        n_checks++; if (rd !== 32'h1234_5678) begin $display("FAIL rd04_data got %h want 12345678", rd); n_fail++; end
        n_checks++; if (e !== 1'b0) begin $display("FAIL rd04_err got %b want 0", e); n_fail++; end
        n_checks++; if (n != 3) begin $display("FAIL rd04_latency got %0d want 3", n); n_fail++; end
    endtask

    task automatic test_id_reg();
        logic [31:0] rd; logic e; int n;
        xfer(0, 0, 32'h00, 32'h0, rd, e, n);
        n_checks++; if (rd !== 32'hA9B0_0001) begin $display("FAIL id_read got %h want a9b00001", rd); n_fail++; end
        n_checks++; if (e !== 1'b0) begin $display("FAIL id_read_err got %b want 0", e); n_fail++; end
        xfer(0, 1, 32'h00, 32'hFFFF_FFFF, rd, e, n);
        n_checks++; if (e !== 1'b1) begin $display("FAIL id_write_err got %b want 1", e); n_fail++; end
        xfer(0, 0, 32'h00, 32'h0, rd, e, n);
        n_checks++; if (rd !== 32'hA9B0_0001) begin $display("FAIL id_reread got %h want a9b00001", rd); n_fail++; end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int n;
        xfer(0, 0, 32'h40, 32'h0, rd, e, n);
        n_checks++; if (e !== 1'b1) begin $display("FAIL rd40_err got %b want 1", e); n_fail++; end
        n_checks++; if (rd !== 32'h0) begin $display("FAIL rd40_data got %h want 0", rd); n_fail++; end
        xfer(0, 0, 32'h06, 32'h0, rd, e, n);
        n_checks++; if (e !== 1'b1) begin $display("FAIL rd06_err got %b want 1", e); n_fail++; end
        n_checks++; if (rd !== 32'h0) begin $display("FAIL rd06_data got %h want 0", rd); n_fail++; end
        xfer(0, 1, 32'h44, 32'hFFFF_0000, rd, e, n);
        n_checks++; if (e !== 1'b1) begin $display("FAIL wr44_err got %b want 1", e); n_fail++; end
        xfer(0, 1, 32'h06, 32'h0000_FFFF, rd, e, n);
        n_checks++; if (e !== 1'b1) begin $display("FAIL wr06_err got %b want 1", e); n_fail++; end
        xfer(0, 0, 32'h04, 32'h0, rd, e, n);
        n_checks++; if (rd !== 32'h1234_5678) begin $display("FAIL err_nochange got %h want 12345678", rd); n_fail++; end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e1, e2; int n;
        xfer(0, 1, 32'h08, 32'hAA, rd, e1, n);
        xfer(0, 1, 32'h0C, 32'hBB, rd, e2, n);
        n_checks++; if ({e1, e2} !== 2'b00) begin $display("FAIL b2b_err got %b want 00", {e1, e2}); n_fail++; end
        xfer(0, 0, 32'h08, 32'h0, rd, e1, n);
        n_checks++; if (rd !== 32'hAA) begin $display("FAIL b2b_rd08 got %h want aa", rd); n_fail++; end
        xfer(0, 0, 32'h0C, 32'h0, rd, e1, n);
        n_checks++; if (rd !== 32'hBB) begin $display("FAIL b2b_rd0c got %h want bb", rd); n_fail++; end
    endtask

    task automatic test_penable_only();
        logic seen = 1'b0;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h04;
        for (int i = 0; i < 4; i++) begin @(negedge clk); seen |= pready; end
        n_checks++; if (seen !== 1'b0) begin $display("FAIL penable_only pready got %b want 0", seen); n_fail++; end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic e; int n;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFE_F00D;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        n_checks++; if (pready !== 1'b0) begin $display("FAIL abort_pready got %b want 0", pready); n_fail++; end
        @(posedge clk); #1;
        xfer(0, 0, 32'h10, 32'h0, rd, e, n);
        n_checks++; if (rd !== 32'h0) begin $display("FAIL abort_rd10 got %h want 0", rd); n_fail++; end
    endtask

    task automatic test_wait0();
        logic [31:0] rd; logic e; int n;
        xfer(1, 1, 32'h18, 32'h55, rd, e, n);
        n_checks++; if (n != 1) begin $display("FAIL w0_wr_latency got %0d want 1", n); n_fail++; end
        n_checks++; if (e !== 1'b0) begin $display("FAIL w0_wr_err got %b want 0", e); n_fail++; end
        xfer(1, 0, 32'h18, 32'h0, rd, e, n);
        n_checks++; if (n != 1) begin $display("FAIL w0_rd_latency got %0d want 1", n); n_fail++; end
        n_checks++; if (rd !== 32'h55) begin $display("FAIL w0_rd_data got %h want 55", rd); n_fail++; end
    endtask

`ifdef APB_PSTRB_EN
    task automatic test_pstrb();
        logic [31:0] rd; logic e; int n;
        pstrb = 4'b0101;
        xfer(0, 1, 32'h14, 32'hDEAD_BEEF, rd, e, n);
        pstrb = 4'hF;
        n_checks++; if (e !== 1'b0) begin $display("FAIL pstrb_err got %b want 0", e); n_fail++; end
        xfer(0, 0, 32'h14, 32'h0, rd, e, n);
        n_checks++; if (rd !== 32'h00AD_00EF) begin $display("FAIL pstrb_rd got %h want 00ad00ef", rd); n_fail++; end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] rd; logic e; int n;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h7777_7777;
        @(posedge clk); #1 penable = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (pready !== 1'b0) begin $display("FAIL rstmid_pready got %b want 0", pready); n_fail++; end
        n_checks++; if (prdata !== 32'h0) begin $display("FAIL rstmid_prdata got %h want 0", prdata); n_fail++; end
        @(posedge clk); #1 rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        xfer(0, 0, 32'h10, 32'h0, rd, e, n);
        n_checks++; if (rd !== 32'h0) begin $display("FAIL rstmid_rd10 got %h want 0", rd); n_fail++; end
        xfer(0, 0, 32'h04, 32'h0, rd, e, n);
        n_checks++; if (rd !== 32'h0) begin $display("FAIL rstmid_rd04 got %h want 0", rd); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_read_write();
        test_id_reg();
        test_errors();
        test_back_to_back();
        test_penable_only();
        test_abort();
        test_wait0();
`ifdef APB_PSTRB_EN
        test_pstrb();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
